// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add 32x32 multiplier feeding the HI/LO write port.
// Signed ops 0/2 exist only when MUL_SIGNED_EN is defined; otherwise every op is unsigned.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [1:0]       mul_mode,
  output logic [WIDTH-1:0] wr_hi,
  output logic [WIDTH-1:0] wr_lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod_q, prod_d;
  logic neg_q, neg_d, acc_mode_q, acc_mode_d;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] a_in, b_in;
  logic neg_in;
`ifdef MUL_SIGNED_EN
  logic sgn;
  assign sgn    = ~op[0];
  assign a_in   = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_in   = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
  assign neg_in = sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`else
  assign a_in   = src_a;
  assign b_in   = src_b;
  assign neg_in = 1'b0;
`endif
  // upper accumulator half plus multiplicand, carry kept for the right shift
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? mcand_q : {WIDTH{1'b0}}};
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    acc_mode_d = acc_mode_q;
    prod_d     = prod_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = RUN;
        cnt_d      = '0;
        mcand_d    = a_in;
        acc_d      = {{WIDTH{1'b0}}, b_in};
        neg_d      = neg_in;
        acc_mode_d = op[1];
      end
      RUN: begin
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? SIGN : RUN;
      end
      SIGN: begin
        prod_d  = neg_q ? -acc_q : acc_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      acc_mode_q <= 1'b0;
      prod_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      acc_mode_q <= acc_mode_d;
      prod_q     <= prod_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign wr_en    = done;
  assign mul_mode = done ? (acc_mode_q ? 2'd2 : 2'd1) : 2'd0;
  assign wr_hi    = prod_q[2*WIDTH-1:WIDTH];
  assign wr_lo    = prod_q[WIDTH-1:0];
endmodule
